// File: rtl/onewire_master.sv
// 1-Wire bus master: reset/presence and LSB-first read/write slot sequences,
// standard or overdrive timing, derived from a quarter-microsecond tick.
`timescale 1ns/1ps
module onewire_master #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_op,
    input  logic                          cmd_overdrive,
    input  logic [$clog2(DATA_W+1)-1:0]   cmd_nbits,
    input  logic [DATA_W-1:0]             cmd_data,
    output logic                          rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          rsp_presence,
    output logic                          busy,
    output logic                          ow_drive_low,
    input  logic                          ow_in
);

    localparam int unsigned TICK_DIV = CLK_FREQ_HZ / 4_000_000;
    localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned NB_W     = $clog2(DATA_W + 1);
    localparam int unsigned TW       = 11;

    localparam int unsigned RST_LOW_STD  = 1920;
    localparam int unsigned RST_LOW_OD   = 280;
    localparam int unsigned RST_SAMP_STD = 280;
    localparam int unsigned RST_SAMP_OD  = 34;
    localparam int unsigned RST_END_STD  = 1920;
    localparam int unsigned RST_END_OD   = 192;
    localparam int unsigned LOW1_STD     = 24;
    localparam int unsigned LOW1_OD      = 4;
    localparam int unsigned LOW0_STD     = 240;
    localparam int unsigned LOW0_OD      = 30;
    localparam int unsigned SAMP_STD     = 60;
    localparam int unsigned SAMP_OD      = 8;
    localparam int unsigned SLOT_STD     = 280;
    localparam int unsigned SLOT_OD      = 40;

    typedef enum logic [2:0] {
        IDLE, RST_LOW, RST_SAMPLE, RST_REC, SLOT_LOW, SLOT_SAMPLE, SLOT_REC, DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [PW-1:0]          pre_cnt;
    logic [TW-1:0]          tcnt;
    logic                   op_q;
    logic                   od_q;
    logic [NB_W-1:0]        nbits_q;
    logic [NB_W-1:0]        bits_left;
    logic [DATA_W-1:0]      tx_q;
    logic [DATA_W-1:0]      rx_q;
    logic                   presence_q;

    logic                   ow_s;
    logic                   tick;
    logic [TW-1:0]          tnext;
    logic                   accept;
    logic [NB_W-1:0]        nb_eff;
    logic                   fin;
    logic [TW-1:0]          t_rst_low, t_rst_samp, t_rst_end;
    logic [TW-1:0]          t_slot_low, t_slot_samp, t_slot_end;

    assign ow_s   = sync_q[SYNC_STAGES-1];
    assign tick   = (pre_cnt == PW'(TICK_DIV - 1));
    assign tnext  = tcnt + TW'(1);
    assign accept = cmd_valid & cmd_ready;
    assign nb_eff = (cmd_nbits == '0 || cmd_nbits > NB_W'(DATA_W)) ? NB_W'(DATA_W) : cmd_nbits;

    // Phase lengths in ticks for the latched speed and current write bit
    always_comb begin
        t_rst_low   = od_q ? TW'(RST_LOW_OD)  : TW'(RST_LOW_STD);
        t_rst_samp  = od_q ? TW'(RST_SAMP_OD) : TW'(RST_SAMP_STD);
        t_rst_end   = od_q ? TW'(RST_END_OD)  : TW'(RST_END_STD);
        t_slot_samp = od_q ? TW'(SAMP_OD)     : TW'(SAMP_STD);
        t_slot_end  = od_q ? TW'(SLOT_OD)     : TW'(SLOT_STD);
        t_slot_low  = tx_q[0] ? (od_q ? TW'(LOW1_OD) : TW'(LOW1_STD))
                              : (od_q ? TW'(LOW0_OD) : TW'(LOW0_STD));
    end

    assign fin = tick && ((state == RST_REC && tnext == t_rst_end) ||
                          (state == SLOT_REC && tnext == t_slot_end && bits_left <= NB_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sync_q       <= '1;
            pre_cnt      <= '0;
            tcnt         <= '0;
            op_q         <= 1'b0;
            od_q         <= 1'b0;
            nbits_q      <= '0;
            bits_left    <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            presence_q   <= 1'b0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_presence <= 1'b0;
            ow_drive_low <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], ow_in};
            pre_cnt   <= tick ? '0 : pre_cnt + PW'(1);
            rsp_valid <= 1'b0;
            if (tick) tcnt <= tnext;

            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (accept) begin
                        op_q         <= cmd_op;
                        od_q         <= cmd_overdrive;
                        nbits_q      <= nb_eff;
                        bits_left    <= nb_eff;
                        tx_q         <= cmd_data;
                        rx_q         <= '0;
                        presence_q   <= 1'b0;
                        pre_cnt      <= '0;
                        tcnt         <= '0;
                        cmd_ready    <= 1'b0;
                        busy         <= 1'b1;
                        ow_drive_low <= 1'b1;
                        state        <= cmd_op ? SLOT_LOW : RST_LOW;
                    end
                end
                RST_LOW: begin
                    if (tick && tnext == t_rst_low) begin
                        ow_drive_low <= 1'b0;
                        tcnt         <= '0;
                        state        <= RST_SAMPLE;
                    end
                end
                RST_SAMPLE: begin
                    if (tick && tnext == t_rst_samp) begin
                        presence_q <= ~ow_s;
                        state      <= RST_REC;
                    end
                end
                RST_REC: ;
                SLOT_LOW: begin
                    // A 0 bit is still driving low at the sample point
                    if (tick && tnext == t_slot_samp)
                        rx_q <= (rx_q >> 1) | (DATA_W'(ow_s) << (DATA_W - 1));
                    if (tick && tnext == t_slot_low) begin
                        ow_drive_low <= 1'b0;
                        state        <= SLOT_SAMPLE;
                    end
                end
                SLOT_SAMPLE: begin
                    if (tcnt >= t_slot_samp) begin
                        state <= SLOT_REC;
                    end else if (tick && tnext == t_slot_samp) begin
                        rx_q  <= (rx_q >> 1) | (DATA_W'(ow_s) << (DATA_W - 1));
                        state <= SLOT_REC;
                    end
                end
                SLOT_REC: begin
                    if (tick && tnext == t_slot_end && bits_left > NB_W'(1)) begin
                        bits_left    <= bits_left - NB_W'(1);
                        tx_q         <= tx_q >> 1;
                        tcnt         <= '0;
                        ow_drive_low <= 1'b1;
                        state        <= SLOT_LOW;
                    end
                end
                default: state <= IDLE;
            endcase

            // Completion: publish response and reopen the command port
            if (fin) begin
                state        <= DONE;
                rsp_valid    <= 1'b1;
                cmd_ready    <= 1'b1;
                busy         <= 1'b0;
                rsp_data     <= op_q ? (rx_q >> (NB_W'(DATA_W) - nbits_q)) : '0;
                rsp_presence <= op_q ? 1'b0 : presence_q;
            end
        end
    end

endmodule

// File: tb/tb_onewire_master.sv
// Directed bench for onewire_master with a simple slave model and a response/pulse-width scoreboard.
`timescale 1ns/1ps
module tb_onewire_master;

    localparam int TICK_DIV = 12;
    localparam int LIMIT    = 60000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_op = 1'b0;
    logic       cmd_overdrive = 1'b0;
    logic [3:0] cmd_nbits = '0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_presence;
    logic       busy;
    logic       ow_drive_low;
    logic       ow_in;

    logic       slave_low = 1'b0;
    int         slave_mode = 0;
    logic [7:0] slave_bits = '0;
    int         slave_idx = 0;

    typedef struct { logic [7:0] d; logic p; } rsp_t;
    rsp_t   exp_q[$];
    int     exp_w[$];
    int     passed = 0, failed = 0, total = 0;
    int     rsp_cnt = 0, slot_starts = 0, lowcnt = 0;
    bit     chk_w = 1'b1;
    longint t_acc = 0, t_rsp = 0;
    logic   rdy_rsp;

    always #10 clk = ~clk;

    assign ow_in = ~ow_drive_low & ~slave_low;

    onewire_master #(.CLK_FREQ_HZ(50_000_000), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_overdrive(cmd_overdrive), .cmd_nbits(cmd_nbits), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_presence(rsp_presence),
        .busy(busy), .ow_drive_low(ow_drive_low), .ow_in(ow_in)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave: presence pulse 30..150 us after reset release, or hold 0-bits low for 5 us
    always begin
        @(ow_drive_low);
        if (ow_drive_low && slave_mode == 2) begin
            if (!slave_bits[slave_idx[2:0]]) begin
                slave_idx++;
                slave_low = 1'b1;
                #5000 slave_low = 1'b0;
            end else begin
                slave_idx++;
            end
        end else if (!ow_drive_low && slave_mode == 1) begin
            #30000  slave_low = 1'b1;
            #120000 slave_low = 1'b0;
        end
    end

    // Monitor: drive-low pulse widths and responses
    always @(negedge clk) begin
        if (!rst_n) begin
            lowcnt = 0;
        end else if (ow_drive_low) begin
            if (lowcnt == 0) slot_starts++;
            lowcnt++;
        end else if (lowcnt != 0) begin
            if (chk_w) begin
                if (exp_w.size() > 0) check("low_width", 64'(lowcnt), 64'(exp_w.pop_front()));
                else                  check("low_width_extra", 64'(lowcnt), 64'(0));
            end
            lowcnt = 0;
        end
        if (rsp_valid) begin
            rsp_t e;
            rsp_cnt++;
            t_rsp = longint'($time);
            check("ready_with_rsp", 64'(cmd_ready), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_data", 64'(rsp_data), 64'(e.d));
                check("rsp_presence", 64'(rsp_presence), 64'(e.p));
            end else begin
                check("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end
        end
    end

    task automatic issue(input logic op, input logic od, input logic [3:0] nb, input logic [7:0] data,
                         input logic [7:0] exp_d, input logic exp_p, input bit push);
        int n;
        int waited;
        rsp_t e;
        cmd_op = op; cmd_overdrive = od; cmd_nbits = nb; cmd_data = data; cmd_valid = 1'b1;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < LIMIT) begin
            @(negedge clk);
            waited++;
        end
        check("accept", 64'(cmd_ready), 64'(1));
        rdy_rsp = rsp_valid;
        if (push) begin
            e.d = exp_d; e.p = exp_p;
            exp_q.push_back(e);
            n = (nb == 0) ? 8 : int'(nb);
            if (!op) exp_w.push_back((od ? 280 : 1920) * TICK_DIV);
            else for (int i = 0; i < n; i++)
                exp_w.push_back((data[i] ? (od ? 4 : 24) : (od ? 30 : 240)) * TICK_DIV);
        end
        @(posedge clk);
        t_acc = longint'($time);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n0);
        int waited = 0;
        while (rsp_cnt == n0 && waited < LIMIT) begin
            @(negedge clk);
            waited++;
        end
        check("rsp_arrived", 64'(rsp_cnt != n0), 64'(1));
    endtask

    initial begin
        int n0;
        int base;
        int waited;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_rsp_presence", 64'(rsp_presence), 64'(0));
        check("rst_drive_low", 64'(ow_drive_low), 64'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: std reset with presence
        slave_mode = 1;
        n0 = rsp_cnt;
        issue(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        check("busy_when_running", 64'(busy), 64'(1));
        wait_rsp(n0);
        check("latency_rst_std", 64'((t_rsp - t_acc - 10) / 20), 64'(3840 * TICK_DIV));
        slave_mode = 0;
        @(negedge clk);
        check("rsp_one_cycle", 64'(rsp_valid), 64'(0));

        // 2: overdrive reset, no slave
        n0 = rsp_cnt;
        issue(1'b0, 1'b1, 4'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        wait_rsp(n0);
        check("latency_rst_od", 64'((t_rsp - t_acc - 10) / 20), 64'(472 * TICK_DIV));
        @(negedge clk);

        // 3: std write A5 on passive bus
        n0 = rsp_cnt;
        issue(1'b1, 1'b0, 4'd8, 8'hA5, 8'hA5, 1'b0, 1'b1);
        wait_rsp(n0);
        @(negedge clk);

        // 4: overdrive read of 4 bits, slave returns 1,0,1,1
        slave_mode = 2; slave_bits = 8'b0000_1101; slave_idx = 0;
        n0 = rsp_cnt;
        issue(1'b1, 1'b1, 4'd4, 8'hFF, 8'h0D, 1'b0, 1'b1);
        wait_rsp(n0);
        slave_mode = 0;
        @(negedge clk);

        // 5: back-to-back, second command waiting while busy; nbits=0 means 8
        n0 = rsp_cnt;
        issue(1'b1, 1'b1, 4'd2, 8'h03, 8'h03, 1'b0, 1'b1);
        issue(1'b1, 1'b1, 4'd0, 8'h3C, 8'h3C, 1'b0, 1'b1);
        check("b2b_accept_on_rsp", 64'(rdy_rsp), 64'(1));
        @(negedge clk);
        check("b2b_started_low", 64'(ow_drive_low), 64'(1));
        check("b2b_ready_dropped", 64'(cmd_ready), 64'(0));
        n0 = rsp_cnt;
        wait_rsp(n0);
        check("b2b_queue_empty", 64'(exp_w.size()), 64'(0));
        @(negedge clk);

        // 6: reset asserted during the low phase of bit 3
        chk_w = 1'b0;
        base = slot_starts;
        issue(1'b1, 1'b1, 4'd8, 8'h00, 8'h00, 1'b0, 1'b0);
        waited = 0;
        while (slot_starts < base + 4 && waited < LIMIT) begin
            @(negedge clk);
            waited++;
        end
        check("abort_reached_bit3", 64'(slot_starts), 64'(base + 4));
        repeat (5) @(negedge clk);
        check("abort_low_before", 64'(ow_drive_low), 64'(1));
        n0 = rsp_cnt;
        rst_n = 1'b0;
        #1;
        check("abort_release_async", 64'(ow_drive_low), 64'(0));
        check("abort_ready_async", 64'(cmd_ready), 64'(1));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2000) @(negedge clk);
        check("abort_no_rsp", 64'(rsp_cnt), 64'(n0));
        check("abort_ready_after", 64'(cmd_ready), 64'(1));
        check("abort_idle_bus", 64'(ow_drive_low), 64'(0));
        check("abort_scoreboard", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
